// File: rtl/encmul_pkg.sv
// Shared types and helpers for the byte-serial encoded mantissa multiplier.
package encmul_pkg;
   localparam int MW = 53;
   localparam int NB = 7;
   localparam int PW = MW + 8*NB;
   localparam int JW = $clog2(NB);

   typedef enum logic [1:0] {IDLE, SCAN, SPLIT, DONE} state_t;

   function automatic logic [2:0] lsb_idx8(input logic [7:0] bits);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (bits[i]) r = 3'(i);
      end
      return r;
   endfunction
endpackage

// File: rtl/encoded_mul_seq_onehot_idx8.sv
// Byte classifier: zero / one-hot / multi-one, with one-hot index and lowest set bit.
module onehot_idx8
   import encmul_pkg::*;
(
   input  logic [7:0] bits,
   output logic       is_zero,
   output logic       is_onehot,
   output logic [2:0] idx,
   output logic [2:0] lsb
);
   assign is_zero   = (bits == 8'd0);
   // Clearing the lowest set bit leaves zero only when exactly one bit was set.
   assign is_onehot = !is_zero && ((bits & (bits - 8'd1)) == 8'd0);
   assign idx       = {|bits[7:4], |{bits[7:6], bits[3:2]}, |{bits[7], bits[5], bits[3], bits[1]}};
   assign lsb       = lsb_idx8(bits);
endmodule

// File: rtl/encoded_mul_seq.sv
// Sequential a*b multiplier walking b one byte per cycle; multi-one bytes split
// into single-bit steps and trailing zero bytes are skipped.
module encoded_mul_seq
   import encmul_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MW-1:0]     a,
   input  logic [8*NB-1:0]   b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PW-1:0]     p
);
   state_t            state;
   logic [MW-1:0]     a_r;
   logic [8*NB-1:0]   b_r;
   logic [PW-1:0]     acc;
   logic [JW-1:0]     j;
   logic [7:0]        residual;

   logic [7:0]        byte_j;
   logic [7:0]        enc_val;
   logic [7:0]        res_next;
   logic              is_zero;
   logic              is_onehot;
   logic [2:0]        idx;
   logic [2:0]        lsb;
   logic [2:0]        bit_sel;
   logic [PW-1:0]     addend;
   logic [PW-1:0]     acc_next;
   logic              upper_zero;

   assign byte_j  = 8'(b_r >> (8*int'(j)));
   assign enc_val = (state == SPLIT) ? residual : byte_j;

   onehot_idx8 u_enc (
      .bits      (enc_val),
      .is_zero   (is_zero),
      .is_onehot (is_onehot),
      .idx       (idx),
      .lsb       (lsb)
   );

   assign bit_sel    = is_onehot ? idx : lsb;
   assign addend     = {{(PW-MW){1'b0}}, a_r} << (8*int'(j) + int'(bit_sel));
   assign acc_next   = acc + (is_zero ? '0 : addend);
   assign res_next   = enc_val & (enc_val - 8'd1);
   // Nothing left to add once every byte above j is zero.
   assign upper_zero = ((b_r >> (8*(int'(j) + 1))) == '0);

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_r      <= '0;
         b_r      <= '0;
         acc      <= '0;
         j        <= '0;
         residual <= '0;
         p        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  acc      <= '0;
                  j        <= '0;
                  residual <= '0;
                  if (b == '0) begin
                     p     <= '0;
                     state <= DONE;
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            SCAN: begin
               acc <= acc_next;
               if (!is_zero && !is_onehot) begin
                  residual <= res_next;
                  state    <= SPLIT;
               end else if (upper_zero) begin
                  p     <= acc_next;
                  state <= DONE;
               end else begin
                  j <= j + JW'(1);
               end
            end
            SPLIT: begin
               acc      <= acc_next;
               residual <= res_next;
               if (res_next == 8'd0) begin
                  if (upper_zero) begin
                     p     <= acc_next;
                     state <= DONE;
                  end else begin
                     j     <= j + JW'(1);
                     state <= SCAN;
                  end
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
